io_port_responder: RTL
======================

Name: io_port_responder

Overview:
- Device-side responder for the processor's `in`/`out` instructions (opcode 4'b1100).
- Buffers words written by `out` (OutputWrite pulse) in an output FIFO and drains them to an external device over a valid/ready handshake.
- Accepts words from the external device into an input FIFO.
- Presents the input FIFO head combinationally so that the `in` state can write it to the register file in the same cycle.

Parameters:
- WIDTH, 16, data word width; matches register width.
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- PTR_W, log2(DEPTH), pointer width; derived, do not override.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset.
- OutputWrite  input  1  from control unit; push OutData this cycle.
- OutData  input  WIDTH  word to output (register file read port A).
- InputRead  input  1  from control unit `in` state; pop input FIFO head this cycle.
- InData  output  WIDTH  input FIFO head (show-ahead); 0 when empty.
- InEmpty  output  1  input FIFO empty.
- OutFull  output  1  output FIFO full.
- ErrFlags  output  2  sticky: [0] output overflow, [1] input underflow.
- dev_out_valid  output  1  output FIFO non-empty.
- dev_out_ready  input  1  device accepts dev_out_data.
- dev_out_data  output  WIDTH  output FIFO head.
- dev_in_valid  input  1  device offers dev_in_data.
- dev_in_ready  output  1  input FIFO can accept.
- dev_in_data  input  WIDTH  word from device.

Behaviour:
- Reset low (async): all pointers and counts 0; ErrFlags=0; dev_out_valid=0; dev_in_ready=1; InEmpty=1; OutFull=0; InData=0; dev_out_data=0.
- Each FIFO has write pointer, read pointer and count (PTR_W+1 bits). Pointers wrap modulo DEPTH. Full when count==DEPTH; empty when count==0.
- Output push: OutputWrite && (!OutFull || pop this cycle). The word is stored at the next edge.
- OutputWrite while full with no pop: word dropped, ErrFlags[0] set, FIFO unchanged.
- Output pop: dev_out_valid && dev_out_ready at the posedge.
- Simultaneous push and pop on the output FIFO: count unchanged, both pointers advance. This holds when full and when count==1.
- Push into an empty output FIFO: dev_out_valid rises the next cycle (1-cycle latency).
- dev_out_data equals the head and is held stable while valid && !ready.
- Input push: dev_in_valid && dev_in_ready.
- dev_in_ready = !full || InputRead, so a push at full is allowed when a pop occurs in the same cycle.
- Input pop: InputRead && !InEmpty.
- InputRead while empty: no state change, ErrFlags[1] set, InData reads 0.
- InData and dev_out_data are combinational from storage and pointers; no registered output stage.
- A word pushed at edge N is visible on InData after edge N, for an `in` executing at N+1.
- ErrFlags clear only on reset.
- Reset mid-transfer discards all buffered words. Device handshakes in progress are abandoned; the device must re-offer.
- OutputWrite and InputRead are single-cycle pulses from the control unit. Each asserted cycle counts as one operation.

Optional Feature:
- Macro: IO_LOOPBACK_EN.
- When defined:
  - Add input port loopback (1 bit).
  - While loopback=1, the output FIFO head pops into the input FIFO whenever the output FIFO is non-empty and the input FIFO is not full (or is popped by InputRead the same cycle).
  - Transfer rate is one word per cycle.
  - dev_out_valid and dev_in_ready are forced to 0; dev_* inputs are ignored.
- When undefined: the port is absent and the FIFOs are independent as above.

Test Plan:
- Reset low for 2 cycles, then release -> InEmpty=1, OutFull=0, dev_out_valid=0, dev_in_ready=1, ErrFlags=0, InData=0.
- OutputWrite with 0x1234, 0xBEEF, 0x0001, 0xFFFF while dev_out_ready=0 -> OutFull=1; a fifth write of 0x5555 sets ErrFlags[0]=1; then dev_out_ready=1 drains 0x1234, 0xBEEF, 0x0001, 0xFFFF in order and dev_out_valid falls.
- Output FIFO full and dev_out_ready=1, OutputWrite 0xAAAA in the same cycle -> no overflow flag; OutFull stays 1; 0xAAAA emerges after the four prior words.
- Device pushes 0x00C3 -> InEmpty=0 and InData=0x00C3 the next cycle; InputRead pulse -> InEmpty=1 and InData=0 after the edge.
- InputRead with InEmpty=1 -> ErrFlags[1]=1, pointers unchanged; a subsequent device push of 0x0042 is still read correctly.
- With IO_LOOPBACK_EN defined and loopback=1: OutputWrite 0x0F0F -> InData=0x0F0F two cycles later; dev_out_valid stays 0 throughout. Reset asserted mid-sequence -> both FIFOs empty.

Source files
------------

// File: rtl/io_port_responder_if.sv
// io_port_responder_if: device-side valid/ready channels of the I/O port responder.
// master = responder, slave = external device.
interface io_port_responder_if #(parameter int WIDTH = 16);
    logic             dev_out_valid;
    logic             dev_out_ready;
    logic [WIDTH-1:0] dev_out_data;
    logic             dev_in_valid;
    logic             dev_in_ready;
    logic [WIDTH-1:0] dev_in_data;
    modport master (
        output dev_out_valid, dev_out_data, dev_in_ready,
        input  dev_out_ready, dev_in_valid, dev_in_data
    );
    modport slave (
        input  dev_out_valid, dev_out_data, dev_in_ready,
        output dev_out_ready, dev_in_valid, dev_in_data
    );
endinterface

// File: rtl/io_port_responder.sv
// io_port_responder: output/input FIFOs behind the processor's in/out instructions.
// Optional IO_LOOPBACK_EN adds a loopback port routing the output FIFO into the input FIFO.
module io_port_responder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             OutputWrite,
    input  logic [WIDTH-1:0] OutData,
    input  logic             InputRead,
    output logic [WIDTH-1:0] InData,
    output logic             InEmpty,
    output logic             OutFull,
    output logic [1:0]       ErrFlags,
`ifdef IO_LOOPBACK_EN
    input  logic             loopback,
`endif
    io_port_responder_if.master devIf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] fullCount = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] outMem [DEPTH];
    logic [WIDTH-1:0] inMem [DEPTH];
    logic [PTR_W-1:0] outWrPtr, outRdPtr, inWrPtr, inRdPtr;
    logic [PTR_W:0]   outCount, inCount;
    logic             loopOn, outEmpty, inFull, loopMove;
    logic             outPush, outPop, inPush, inPop;
    logic [WIDTH-1:0] outHead, inWrData;

`ifdef IO_LOOPBACK_EN
    assign loopOn = loopback;
`else
    assign loopOn = 1'b0;
`endif

    assign outEmpty = outCount == '0;
    assign OutFull  = outCount == fullCount;
    assign InEmpty  = inCount == '0;
    assign inFull   = inCount == fullCount;
    assign outHead  = outEmpty ? '0 : outMem[outRdPtr];
    assign InData   = InEmpty ? '0 : inMem[inRdPtr];

    assign devIf.dev_out_valid = !outEmpty && !loopOn;
    assign devIf.dev_out_data  = outHead;
    assign devIf.dev_in_ready  = (!inFull || InputRead) && !loopOn;

    // Loopback moves the output head straight into the input FIFO, one word per cycle
    assign loopMove = loopOn && !outEmpty && (!inFull || InputRead);
    assign outPop   = loopOn ? loopMove : devIf.dev_out_valid && devIf.dev_out_ready;
    assign outPush  = OutputWrite && (!OutFull || outPop);
    assign inPop    = InputRead && !InEmpty;
    assign inPush   = loopOn ? loopMove : devIf.dev_in_valid && devIf.dev_in_ready;
    assign inWrData = loopOn ? outHead : devIf.dev_in_data;

    always_ff @(posedge CLK) begin
        if (outPush) outMem[outWrPtr] <= OutData;
        if (inPush) inMem[inWrPtr] <= inWrData;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            outWrPtr <= '0;
            outRdPtr <= '0;
            outCount <= '0;
            inWrPtr  <= '0;
            inRdPtr  <= '0;
            inCount  <= '0;
            ErrFlags <= '0;
        end else begin
            if (outPush) outWrPtr <= outWrPtr + PTR_W'(1);
            if (outPop) outRdPtr <= outRdPtr + PTR_W'(1);
            outCount <= outCount + (PTR_W+1)'(outPush) - (PTR_W+1)'(outPop);
            if (inPush) inWrPtr <= inWrPtr + PTR_W'(1);
            if (inPop) inRdPtr <= inRdPtr + PTR_W'(1);
            inCount <= inCount + (PTR_W+1)'(inPush) - (PTR_W+1)'(inPop);
            if (OutputWrite && OutFull && !outPop) ErrFlags[0] <= 1'b1;
            if (InputRead && InEmpty) ErrFlags[1] <= 1'b1;
        end
    end
endmodule
